// File: rtl/mem_responder_pkg.sv
// Shared decode constants, status layout and small helpers for the CPU data-bus responder.
package mem_responder_pkg;

  localparam int         IoSelBit  = 17;
  localparam logic [2:0] IoDataOff = 3'd0;
  localparam logic [2:0] IoCtrlOff = 3'd4;

  localparam int StTxFullBit    = 0;
  localparam int StRxNonemptyBit = 1;
  localparam int StHaltBit      = 2;

  localparam logic [7:0]  Zero8    = 8'h00;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  // No real access can match this, so the first cycle after reset is always "new".
  localparam logic [31:0] PrevAddrRst = ~ZeroWord;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_DATA,
    SEL_CTRL,
    SEL_NONE
  } mem_sel_e;

  function automatic mem_sel_e decode_sel(input logic io, input logic [2:0] off);
    mem_sel_e sel;
    sel = SEL_NONE;
    if (!io) begin
      sel = SEL_RAM;
    end else if (off == IoDataOff) begin
      sel = SEL_DATA;
    end else if (off == IoCtrlOff) begin
      sel = SEL_CTRL;
    end
    return sel;
  endfunction

  function automatic logic [7:0] status_byte(input logic halt, input logic rx_nonempty,
                                             input logic tx_full);
    logic [7:0] s;
    s = Zero8;
    s[StHaltBit]       = halt;
    s[StRxNonemptyBit] = rx_nonempty;
    s[StTxFullBit]     = tx_full;
    return s;
  endfunction

endpackage

// File: rtl/mem_responder_byte_fifo.sv
// Synchronous byte FIFO; wrap-bit pointers, head reads 0x00 when empty.
module byte_fifo
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_head,
  output logic       o_accept
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
  assign w_pop  = i_pop && !w_empty;
  assign w_push = i_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_head   = w_empty ? Zero8 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_accept = w_push;

endmodule

// File: rtl/mem_responder.sv
// Data-bus target of the CPU MEM stage: byte RAM plus TX/RX FIFOs, status and halt flag.
// Serves one byte per cycle with a registered read path; never stalls.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_AW     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a_i,
  input  logic        mem_wr_i,
  input  logic [7:0]  mem_dout_i,
  output logic [7:0]  mem_din_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        halt_o,
  output logic        tx_overflow_o
);

  logic [7:0]  r_ram [2**RAM_AW];
  logic [7:0]  r_din;
  logic [31:0] r_prev_a;
  logic        r_prev_wr;
  logic        r_halt;
  logic        r_tx_ovf;

  mem_sel_e          w_sel;
  logic [RAM_AW-1:0] w_idx;
  logic              w_first;
  logic [7:0]        w_din_next;

  logic       w_tx_push_req;
  logic       w_tx_accept;
  logic       w_tx_full;
  logic       w_tx_empty;
  logic [7:0] w_tx_head;

  logic       w_rx_push;
  logic       w_rx_pop_req;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic [7:0] w_rx_head;
  logic       w_unused_rx_accept;

  assign w_sel   = decode_sel(mem_a_i[IoSelBit], mem_a_i[2:0]);
  assign w_idx   = mem_a_i[RAM_AW-1:0];
  // The CPU may hold an access for two cycles; only the first one may touch a FIFO.
  assign w_first = (mem_a_i != r_prev_a) || (mem_wr_i != r_prev_wr);

  assign w_tx_push_req = (w_sel == SEL_DATA) && mem_wr_i && w_first;
  assign w_rx_pop_req  = (w_sel == SEL_DATA) && !mem_wr_i && w_first;
  assign w_rx_push     = rx_valid_i && !w_rx_full;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_tx_push_req),
    .i_data   (mem_dout_i),
    .i_pop    (tx_ready_i),
    .o_full   (w_tx_full),
    .o_empty  (w_tx_empty),
    .o_head   (w_tx_head),
    .o_accept (w_tx_accept)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_rx_push),
    .i_data   (rx_data_i),
    .i_pop    (w_rx_pop_req),
    .o_full   (w_rx_full),
    .o_empty  (w_rx_empty),
    .o_head   (w_rx_head),
    .o_accept (w_unused_rx_accept)
  );

  always_ff @(posedge clk) begin
    if ((w_sel == SEL_RAM) && mem_wr_i) r_ram[w_idx] <= mem_dout_i;
  end

  // Read mux; a held DATA read repeats the byte already returned instead of popping again.
  always_comb begin
    w_din_next = Zero8;
    unique case (w_sel)
      SEL_RAM:  w_din_next = r_ram[w_idx];
      SEL_DATA: begin
        if (mem_wr_i)     w_din_next = Zero8;
        else if (w_first) w_din_next = w_rx_head;
        else              w_din_next = r_din;
      end
      SEL_CTRL: w_din_next = status_byte(r_halt, !w_rx_empty, w_tx_full);
      default:  w_din_next = Zero8;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_din     <= Zero8;
      r_prev_a  <= PrevAddrRst;
      r_prev_wr <= 1'b0;
      r_halt    <= 1'b0;
      r_tx_ovf  <= 1'b0;
    end else begin
      r_din     <= w_din_next;
      r_prev_a  <= mem_a_i;
      r_prev_wr <= mem_wr_i;
      if ((w_sel == SEL_CTRL) && mem_wr_i) r_halt <= 1'b1;
      if (w_tx_push_req && !w_tx_accept)   r_tx_ovf <= 1'b1;
    end
  end

  assign mem_din_o     = r_din;
  assign tx_data_o     = w_tx_head;
  assign tx_valid_o    = !w_tx_empty;
  assign rx_ready_o    = !w_rx_full;
  assign halt_o        = r_halt;
  assign tx_overflow_o = r_tx_ovf;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus a randomized run against a queue-based model.
module tb_mem_responder;

  localparam int DEPTH = 8;
  localparam logic [31:0] IDLE   = 32'h0000_0000;
  localparam logic [31:0] A_DATA = 32'h0003_0000;
  localparam logic [31:0] A_CTRL = 32'h0003_0004;
  localparam logic [31:0] A_RSVD = 32'h0003_0002;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_a_i;
  logic        mem_wr_i;
  logic [7:0]  mem_dout_i;
  logic [7:0]  mem_din_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        halt_o;
  logic        tx_overflow_o;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk           (clk),
    .rst           (rst),
    .mem_a_i       (mem_a_i),
    .mem_wr_i      (mem_wr_i),
    .mem_dout_i    (mem_dout_i),
    .mem_din_o     (mem_din_o),
    .tx_data_o     (tx_data_o),
    .tx_valid_o    (tx_valid_o),
    .tx_ready_i    (tx_ready_i),
    .rx_data_i     (rx_data_i),
    .rx_valid_i    (rx_valid_i),
    .rx_ready_o    (rx_ready_o),
    .halt_o        (halt_o),
    .tx_overflow_o (tx_overflow_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: RAM as a sparse map, FIFOs as queues.
  logic [7:0]  ram_m [int];
  logic [7:0]  tx_q [$];
  logic [7:0]  rx_q [$];
  logic        m_halt;
  logic        m_ovf;
  logic [31:0] m_prev_a;
  logic        m_prev_wr;
  logic [7:0]  m_din;
  logic        m_din_known;

  task automatic do_reset(input logic [31:0] a);
    rst        = 1'b1;
    mem_a_i    = a;
    mem_wr_i   = 1'b0;
    mem_dout_i = 8'h00;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    tx_ready_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    tx_q.delete();
    rx_q.delete();
    m_halt      = 1'b0;
    m_ovf       = 1'b0;
    m_prev_a    = 32'hFFFF_FFFF;
    m_prev_wr   = 1'b0;
    m_din       = 8'h00;
    m_din_known = 1'b1;
  endtask

  // One bus cycle: drive inputs, advance the model, then step past the clock edge.
  task automatic tick(input logic [31:0] a, input logic wr, input logic [7:0] d,
                      input logic rxv, input logic [7:0] rxd, input logic txr);
    logic       first;
    logic       tx_push_req;
    logic       rx_pop;
    logic       tx_pop;
    logic       rx_push;
    logic       tx_full_pre;
    logic [7:0] nd;
    logic       nk;
    int         idx;
    mem_a_i    = a;
    mem_wr_i   = wr;
    mem_dout_i = d;
    rx_valid_i = rxv;
    rx_data_i  = rxd;
    tx_ready_i = txr;
    first       = (a != m_prev_a) || (wr != m_prev_wr);
    tx_push_req = 1'b0;
    rx_pop      = 1'b0;
    nd          = 8'h00;
    nk          = 1'b1;
    if (!a[17]) begin
      idx = int'(a[16:0]);
      if (ram_m.exists(idx)) nd = ram_m[idx];
      else nk = 1'b0;
      if (wr) ram_m[idx] = d;
    end else if (wr) begin
      nk = 1'b0;
      if (a[2:0] == 3'd0) tx_push_req = first;
      else if (a[2:0] == 3'd4) m_halt = 1'b1;
    end else begin
      case (a[2:0])
        3'd0: begin
          if (first) begin
            if (rx_q.size() > 0) begin
              nd     = rx_q[0];
              rx_pop = 1'b1;
            end
          end else begin
            nd = m_din;
            nk = m_din_known;
          end
        end
        3'd4:    nd = {5'b0, m_halt, (rx_q.size() > 0), (tx_q.size() == DEPTH)};
        default: nd = 8'h00;
      endcase
    end
    tx_full_pre = (tx_q.size() == DEPTH);
    tx_pop      = txr && (tx_q.size() > 0);
    rx_push     = rxv && (rx_q.size() < DEPTH);
    if (tx_pop) void'(tx_q.pop_front());
    if (tx_push_req) begin
      if (!tx_full_pre || tx_pop) tx_q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (rx_pop) void'(rx_q.pop_front());
    if (rx_push) rx_q.push_back(rxd);
    m_prev_a    = a;
    m_prev_wr   = wr;
    m_din       = nd;
    m_din_known = nk;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset(IDLE);
    n_vec++; if (mem_din_o !== 8'h00) begin n_err++; $display("FAIL rst_din got=%02h exp=00", mem_din_o); end
    n_vec++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid_o); end
    n_vec++; if (tx_data_o !== 8'h00) begin n_err++; $display("FAIL rst_tx_data got=%02h exp=00", tx_data_o); end
    n_vec++; if (rx_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_rx_ready got=%b exp=1", rx_ready_o); end
    n_vec++; if (halt_o !== 1'b0) begin n_err++; $display("FAIL rst_halt got=%b exp=0", halt_o); end
    n_vec++; if (tx_overflow_o !== 1'b0) begin n_err++; $display("FAIL rst_ovf got=%b exp=0", tx_overflow_o); end
  endtask

  task automatic test_ram_rw();
    tick(32'h11, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
    tick(32'h10, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
    tick(32'h10, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'hA5) begin n_err++; $display("FAIL ram_rd1 got=%02h exp=A5", mem_din_o); end
    tick(32'h10, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'hA5) begin n_err++; $display("FAIL ram_rd2 got=%02h exp=A5", mem_din_o); end
    tick(32'h11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'h3C) begin n_err++; $display("FAIL ram_rd_11 got=%02h exp=3C", mem_din_o); end
    tick(32'h10, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'hA5) begin n_err++; $display("FAIL ram_rdw_old got=%02h exp=A5", mem_din_o); end
    // Upper address bits are ignored for RAM indexing.
    tick(32'hABCC_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'h77) begin n_err++; $display("FAIL ram_hi_bits got=%02h exp=77", mem_din_o); end
  endtask

  task automatic test_tx_push();
    tick(A_DATA, 1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
    tick(IDLE,   1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (tx_valid_o !== 1'b1) begin n_err++; $display("FAIL tx_valid1 got=%b exp=1", tx_valid_o); end
    n_vec++; if (tx_data_o !== 8'h41) begin n_err++; $display("FAIL tx_head1 got=%02h exp=41", tx_data_o); end
    tick(A_DATA, 1'b1, 8'h42, 1'b0, 8'h00, 1'b0);
    tick(A_DATA, 1'b1, 8'h42, 1'b0, 8'h00, 1'b0);
    tick(IDLE,   1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    n_vec++; if (tx_data_o !== 8'h42) begin n_err++; $display("FAIL tx_head2 got=%02h exp=42", tx_data_o); end
    tick(IDLE,   1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    n_vec++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL tx_drained got=%b exp=0", tx_valid_o); end
    n_vec++; if (tx_data_o !== 8'h00) begin n_err++; $display("FAIL tx_empty_data got=%02h exp=00", tx_data_o); end
  endtask

  task automatic test_rx_pop();
    tick(IDLE,   1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
    tick(A_DATA, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'h5A) begin n_err++; $display("FAIL rx_rd1 got=%02h exp=5A", mem_din_o); end
    tick(A_DATA, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'h5A) begin n_err++; $display("FAIL rx_rd_held got=%02h exp=5A", mem_din_o); end
    tick(A_CTRL, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'h00) begin n_err++; $display("FAIL rx_ctrl got=%02h exp=00", mem_din_o); end
  endtask

  task automatic test_tx_overflow();
    for (int i = 0; i < 8; i++) begin
      tick(A_DATA, 1'b1, 8'h10 + 8'(i), 1'b0, 8'h00, 1'b0);
      tick(IDLE,   1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    end
    n_vec++; if (tx_overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_early got=%b exp=0", tx_overflow_o); end
    tick(A_DATA, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
    n_vec++; if (tx_overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b exp=1", tx_overflow_o); end
    tick(A_CTRL, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'h01) begin n_err++; $display("FAIL ctrl_txfull got=%02h exp=01", mem_din_o); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = 8'h10 + 8'(i);
      n_vec++; if (tx_data_o !== e) begin n_err++; $display("FAIL drain_%0d got=%02h exp=%02h", i, tx_data_o, e); end
      tick(IDLE, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    end
    n_vec++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_end got=%b exp=0", tx_valid_o); end
    n_vec++; if (tx_overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", tx_overflow_o); end
  endtask

  task automatic test_rx_empty_halt();
    tick(A_DATA, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'h00) begin n_err++; $display("FAIL rx_empty got=%02h exp=00", mem_din_o); end
    tick(A_RSVD, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'h00) begin n_err++; $display("FAIL rsvd_rd got=%02h exp=00", mem_din_o); end
    tick(A_CTRL, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (halt_o !== 1'b1) begin n_err++; $display("FAIL halt_set got=%b exp=1", halt_o); end
    tick(A_CTRL, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'h04) begin n_err++; $display("FAIL ctrl_halt got=%02h exp=04", mem_din_o); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      tick(A_DATA, 1'b1, 8'hC0 + 8'(i), 1'b0, 8'h00, 1'b0);
      tick(IDLE,   1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    end
    n_vec++; if (tx_valid_o !== 1'b1) begin n_err++; $display("FAIL pre_rst_tx got=%b exp=1", tx_valid_o); end
    do_reset(A_DATA);
    n_vec++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_tx got=%b exp=0", tx_valid_o); end
    n_vec++; if (halt_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_halt got=%b exp=0", halt_o); end
    n_vec++; if (mem_din_o !== 8'h00) begin n_err++; $display("FAIL mid_rst_din got=%02h exp=00", mem_din_o); end
    n_vec++; if (tx_overflow_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovf got=%b exp=0", tx_overflow_o); end
    tick(32'h10, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'h77) begin n_err++; $display("FAIL ram_kept_10 got=%02h exp=77", mem_din_o); end
    tick(32'h11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_vec++; if (mem_din_o !== 8'h3C) begin n_err++; $display("FAIL ram_kept_11 got=%02h exp=3C", mem_din_o); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        wr;
    logic [7:0]  exp_tx;
    a  = IDLE;
    wr = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) != 0) begin
        int kind;
        kind = int'($urandom_range(0, 9));
        a = $urandom();
        if ($urandom_range(0, 1) == 0) a[31:18] = '0;
        if (kind < 4) begin
          a[17]   = 1'b0;
          a[16:0] = 17'($urandom_range(0, 31));
        end else begin
          a[17] = 1'b1;
          if (kind < 8) a[2:0] = 3'd0;
          else if (kind == 8) a[2:0] = ($urandom_range(0, 7) == 0) ? 3'd4 : 3'd0;
        end
        wr = ($urandom_range(0, 2) == 0);
      end
      tick(a, wr, 8'($urandom()), 1'($urandom_range(0, 1)), 8'($urandom()),
           ($urandom_range(0, 2) == 0));
      exp_tx = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
      if (m_din_known) begin
        n_vec++; if (mem_din_o !== m_din) begin n_err++; $display("FAIL rnd_din cyc=%0d got=%02h exp=%02h", c, mem_din_o, m_din); end
      end
      n_vec++; if (tx_valid_o !== (tx_q.size() > 0)) begin n_err++; $display("FAIL rnd_tx_valid cyc=%0d got=%b exp=%b", c, tx_valid_o, tx_q.size() > 0); end
      n_vec++; if (tx_data_o !== exp_tx) begin n_err++; $display("FAIL rnd_tx_data cyc=%0d got=%02h exp=%02h", c, tx_data_o, exp_tx); end
      n_vec++; if (rx_ready_o !== (rx_q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_rx_ready cyc=%0d got=%b exp=%b", c, rx_ready_o, rx_q.size() < DEPTH); end
      n_vec++; if (halt_o !== m_halt) begin n_err++; $display("FAIL rnd_halt cyc=%0d got=%b exp=%b", c, halt_o, m_halt); end
      n_vec++; if (tx_overflow_o !== m_ovf) begin n_err++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", c, tx_overflow_o, m_ovf); end
      if (c == 750) do_reset(IDLE);
    end
  endtask

  initial begin
    rst        = 1'b1;
    mem_a_i    = IDLE;
    mem_wr_i   = 1'b0;
    mem_dout_i = 8'h00;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    tx_ready_i = 1'b0;
    test_reset();
    test_ram_rw();
    test_tx_push();
    test_rx_pop();
    test_tx_overflow();
    test_rx_empty_halt();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the byte-serial CPU data bus: a 32-bit address, a write strobe and an 8-bit write byte come in; an 8-bit read byte goes back.
- The bus has no wait signal, so the block serves one byte per cycle and never stalls.
- It holds the byte-addressed data RAM and a small memory-mapped I/O window: a TX byte FIFO, an RX byte FIFO, a status register and a halt flag.
- It sits beside the CPU top and is the only target of the MEM stage's data bus.

Parameters:
- RAM_AW, 17, RAM address width in bits (RAM is 2^RAM_AW bytes).
- FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs; must be a power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mem_a_i  in  32  byte address from the CPU.
- mem_wr_i  in  1  1 = write cycle, 0 = read cycle.
- mem_dout_i  in  8  write byte from the CPU.
- mem_din_o  out  8  read byte to the CPU (registered).
- tx_data_o  out  8  byte at the head of the TX FIFO.
- tx_valid_o  out  1  TX FIFO not empty.
- tx_ready_i  in  1  consumer accepts tx_data_o.
- rx_data_i  in  8  incoming byte.
- rx_valid_i  in  1  rx_data_i is valid.
- rx_ready_o  out  1  RX FIFO not full.
- halt_o  out  1  sticky program-halt flag.
- tx_overflow_o  out  1  sticky: a push was attempted while TX was full.

Behaviour:
- Address decode:
  - mem_a_i[17]==0: RAM access at index mem_a_i[RAM_AW-1:0].
  - mem_a_i[17]==1: IO access, register selected by mem_a_i[2:0]:
    - 0 = DATA.
    - 4 = CTRL.
    - any other offset reads 0x00; writes to it are ignored.
  - Bits 31:18 are ignored.
- RAM write: when mem_wr_i=1, RAM[idx] <= mem_dout_i at the clock edge.
- RAM read: mem_din_o <= RAM[idx] at the edge, giving one cycle of registered latency.
  - If an address is presented after edge k, its data is valid after edge k+1; the CPU samples it at edge k+2.
  - Read-during-write to the same index returns the old byte.
- mem_din_o is updated every cycle, including write cycles (it returns the pre-write content).
- First-cycle rule:
  - The CPU may hold one address for two consecutive cycles.
  - FIFO side effects happen only when the current (mem_a_i, mem_wr_i) differs from the previous cycle's registered value.
  - The previous-cycle register resets to address 0xFFFFFFFF, wr 0.
- DATA write (first cycle): push mem_dout_i into TX.
  - If TX is full, the byte is dropped and tx_overflow_o <= 1.
- DATA read (first cycle): mem_din_o <= RX head and RX pops.
  - If RX is empty, mem_din_o <= 0x00 and nothing pops.
  - A held second cycle returns the same byte without popping again.
- CTRL write: halt_o <= 1, regardless of the data byte.
- CTRL read: mem_din_o <= {5'b0, halt_o, rx_nonempty, tx_full}.
- RX push: when rx_valid_i && rx_ready_o.
- TX pop: when tx_valid_o && tx_ready_i.
- Simultaneous push and pop on the same FIFO:
  - Both take effect and the count is unchanged.
  - When the FIFO is full, a push and pop in the same cycle is allowed only on the TX side (the pop frees a slot in that cycle). RX push is gated by rx_ready_o, so an RX push never occurs while RX is full.
  - When the FIFO is empty, a pop is a no-op.
- FIFO pointers are log2(FIFO_DEPTH) bits plus one wrap bit; full = pointers equal except the wrap bit.
- halt_o and tx_overflow_o stay sticky until rst.
- Reset (takes effect at any time, including mid-access):
  - mem_din_o = 0x00, halt_o = 0, tx_overflow_o = 0.
  - Both FIFOs empty, so tx_valid_o = 0 and rx_ready_o = 1.
  - tx_data_o = 0x00 while TX is empty.
  - RAM contents are not cleared.

Decomposition:
- Shared defines:
  - IoSelBit = 17.
  - IoDataOff = 3'd0.
  - IoCtrlOff = 3'd4.
  - Status bit positions.
  - Reuse the existing Zero8 and ZeroWord constants.
- One sub-module, byte_fifo: synchronous FIFO, parameter DEPTH, with push/pop/full/empty/head ports. It is instantiated twice (TX and RX).

Test Plan:
- Write 0xA5 to 0x00000010 in one cycle, then present 0x10 for two cycles -> mem_din_o = 0xA5 from the edge after the address and stable through the second cycle; 0x11 reads its prior content.
- Write 0x41 to 0x30000, held 1 cycle and then held 2 cycles -> TX count increases by exactly 1 each time; with tx_ready_i=1, tx_data_o = 0x41 and tx_valid_o drops once drained.
- Inject 0x5A on rx_valid_i, then read 0x30000 held 2 cycles -> mem_din_o = 0x5A in both cycles, one pop; CTRL read then returns 0x00.
- Fill TX with 8 writes while tx_ready_i=0, then a 9th write of 0x99 -> the byte is dropped, tx_overflow_o = 1; draining outputs exactly the first 8 bytes in order.
- Read 0x30000 with RX empty -> 0x00; write 0x00 to 0x30004 -> halt_o = 1 and a CTRL read returns 0x04.
- Assert rst mid-stream with TX half full and halt_o set -> next cycle tx_valid_o = 0, halt_o = 0, mem_din_o = 0x00, and previously written RAM bytes are still readable.
